// File: rtl/ni_chan.sv
// Network-interface channel: a core-to-network TX FIFO and a network-to-core RX FIFO,
// each holding {addr,data} words, with occupancy counts, an RX threshold level and sticky error flags.

module ni_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == CNT_W'(0));
   assign full    = (count == CNT_W'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers are exactly log2(DEPTH) wide so they wrap on their own.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately left unreset; the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   assign rdata = empty ? '0 : mem[rd_ptr];
endmodule

module ni_chan #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_W-1:0]        core_write_data,
   input  logic [ADDR_W-1:0]        core_write_addr,
   input  logic                     core_write_en,
   output logic [DATA_W-1:0]        core_read_data,
   output logic [ADDR_W-1:0]        core_read_addr,
   input  logic                     core_read_en,
   output logic                     core_thresh,
   output logic                     core_empty,
   output logic                     core_full,
   input  logic [$clog2(DEPTH):0]   thresh_level,
   output logic                     net_tx_valid,
   input  logic                     net_tx_ready,
   output logic [DATA_W-1:0]        net_tx_data,
   output logic [ADDR_W-1:0]        net_tx_addr,
   input  logic                     net_rx_valid,
   output logic                     net_rx_ready,
   input  logic [DATA_W-1:0]        net_rx_data,
   input  logic [ADDR_W-1:0]        net_rx_addr,
   output logic [$clog2(DEPTH):0]   tx_count,
   output logic [$clog2(DEPTH):0]   rx_count,
   output logic                     err_overflow,
   output logic                     err_underflow,
   input  logic                     err_clear
);
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int WORD_W = ADDR_W + DATA_W;

   logic              tx_empty;
   logic              rx_full;
   logic              tx_pop;
   logic              rx_push;
   logic [WORD_W-1:0] tx_head;
   logic [WORD_W-1:0] rx_head;

   assign net_tx_valid = !tx_empty;
   assign tx_pop       = net_tx_valid && net_tx_ready;
   assign net_rx_ready = !rx_full && !reset;
   assign rx_push      = net_rx_valid && net_rx_ready;

   ni_fifo #(.W(WORD_W), .DEPTH(DEPTH)) u_tx (
      .clk   (clk),
      .reset (reset),
      .push  (core_write_en),
      .pop   (tx_pop),
      .wdata ({core_write_addr, core_write_data}),
      .rdata (tx_head),
      .count (tx_count),
      .empty (tx_empty),
      .full  (core_full)
   );

   ni_fifo #(.W(WORD_W), .DEPTH(DEPTH)) u_rx (
      .clk   (clk),
      .reset (reset),
      .push  (rx_push),
      .pop   (core_read_en),
      .wdata ({net_rx_addr, net_rx_data}),
      .rdata (rx_head),
      .count (rx_count),
      .empty (core_empty),
      .full  (rx_full)
   );

   assign {net_tx_addr, net_tx_data}       = tx_head;
   assign {core_read_addr, core_read_data} = rx_head;

   // A zero level disables the interrupt; levels above DEPTH can never be reached.
   assign core_thresh = (rx_count >= thresh_level) && (thresh_level != CNT_W'(0));

   // A new error in the same cycle as err_clear takes priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         if (core_write_en && core_full)
            err_overflow <= 1'b1;
         else if (err_clear)
            err_overflow <= 1'b0;
         if (core_read_en && core_empty)
            err_underflow <= 1'b1;
         else if (err_clear)
            err_underflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_ni_chan.sv
// Scoreboard bench for ni_chan: directed stimulus queues expected words, and a negedge
// monitor checks every TX/RX handshake against them in order.

module tb_ni_chan;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 64;
   localparam int CNT_W  = 7;

   logic              clk = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] core_write_data;
   logic [ADDR_W-1:0] core_write_addr;
   logic              core_write_en;
   logic [DATA_W-1:0] core_read_data;
   logic [ADDR_W-1:0] core_read_addr;
   logic              core_read_en;
   logic              core_thresh;
   logic              core_empty;
   logic              core_full;
   logic [CNT_W-1:0]  thresh_level;
   logic              net_tx_valid;
   logic              net_tx_ready;
   logic [DATA_W-1:0] net_tx_data;
   logic [ADDR_W-1:0] net_tx_addr;
   logic              net_rx_valid;
   logic              net_rx_ready;
   logic [DATA_W-1:0] net_rx_data;
   logic [ADDR_W-1:0] net_rx_addr;
   logic [CNT_W-1:0]  tx_count;
   logic [CNT_W-1:0]  rx_count;
   logic              err_overflow;
   logic              err_underflow;
   logic              err_clear;

   int checks = 0;
   int errors = 0;
   logic [63:0] txq [$];
   logic [63:0] rxq [$];

   ni_chan #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset           (reset),
      .core_write_data (core_write_data),
      .core_write_addr (core_write_addr),
      .core_write_en   (core_write_en),
      .core_read_data  (core_read_data),
      .core_read_addr  (core_read_addr),
      .core_read_en    (core_read_en),
      .core_thresh     (core_thresh),
      .core_empty      (core_empty),
      .core_full       (core_full),
      .thresh_level    (thresh_level),
      .net_tx_valid    (net_tx_valid),
      .net_tx_ready    (net_tx_ready),
      .net_tx_data     (net_tx_data),
      .net_tx_addr     (net_tx_addr),
      .net_rx_valid    (net_rx_valid),
      .net_rx_ready    (net_rx_ready),
      .net_rx_data     (net_rx_data),
      .net_rx_addr     (net_rx_addr),
      .tx_count        (tx_count),
      .rx_count        (rx_count),
      .err_overflow    (err_overflow),
      .err_underflow   (err_underflow),
      .err_clear       (err_clear)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic txSet(input int id);
      core_write_data = 32'hA500_0000 + 32'(id);
      core_write_addr = 32'h0000_1000 + 32'(id);
      core_write_en   = 1'b1;
   endtask

   task automatic rxSet(input int id);
      net_rx_data  = 32'h5A00_0000 + 32'(id);
      net_rx_addr  = 32'h0000_2000 + 32'(id);
      net_rx_valid = 1'b1;
   endtask

   // Commit the driven inputs across one rising edge; the flags say whether the
   // TX / RX push is expected to be accepted.
   task automatic applyStimulus(input logic tx_acc, input logic rx_acc);
      if (tx_acc)
         txq.push_back({core_write_addr, core_write_data});
      if (rx_acc)
         rxq.push_back({net_rx_addr, net_rx_data});
      @(posedge clk);
      #1;
      core_write_en = 1'b0;
      net_rx_valid  = 1'b0;
      core_read_en  = 1'b0;
      err_clear     = 1'b0;
   endtask

   // Scoreboard monitor: every accepted handshake must match the next queued word.
   always @(negedge clk) begin
      if (!reset && net_tx_valid && net_tx_ready) begin
         if (txq.size() == 0)
            checkOutput("tx_unexpected_word", 64'd1, 64'd0);
         else
            checkOutput("tx_word", {net_tx_addr, net_tx_data}, txq.pop_front());
      end
      if (!reset && core_read_en && !core_empty) begin
         if (rxq.size() == 0)
            checkOutput("rx_unexpected_word", 64'd1, 64'd0);
         else
            checkOutput("rx_word", {core_read_addr, core_read_data}, rxq.pop_front());
      end
   end

   initial begin
      reset           = 1'b1;
      core_write_data = '0;
      core_write_addr = '0;
      core_write_en   = 1'b0;
      core_read_en    = 1'b0;
      thresh_level    = '0;
      net_tx_ready    = 1'b0;
      net_rx_valid    = 1'b0;
      net_rx_data     = '0;
      net_rx_addr     = '0;
      err_clear       = 1'b0;

      @(posedge clk);
      #1;
      checkOutput("rst_core_empty", core_empty, 1);
      checkOutput("rst_core_full", core_full, 0);
      checkOutput("rst_tx_valid", net_tx_valid, 0);
      checkOutput("rst_rx_ready", net_rx_ready, 0);
      checkOutput("rst_counts", {tx_count, rx_count}, 0);
      checkOutput("rst_errs", {err_overflow, err_underflow}, 0);
      checkOutput("rst_data", {net_tx_data, core_read_data}, 0);
      checkOutput("rst_thresh", core_thresh, 0);

      // First push lands on the first edge after reset release; three words in order
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("rx_ready_after_rst", net_rx_ready, 1);
      for (int i = 0; i < 3; i++) begin
         txSet(i);
         applyStimulus(1, 0);
         checkOutput("tx_count_fill", tx_count, 7'(i + 1));
      end
      checkOutput("tx_valid", net_tx_valid, 1);
      applyStimulus(0, 0);
      checkOutput("tx_hold_data", net_tx_data, 32'hA500_0000);
      checkOutput("tx_hold_addr", net_tx_addr, 32'h0000_1000);
      net_tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0);
         checkOutput("tx_count_drain", tx_count, 7'(2 - i));
      end
      net_tx_ready = 1'b0;
      checkOutput("tx_valid_empty", net_tx_valid, 0);
      checkOutput("tx_data_empty", net_tx_data, 0);

      // Simultaneous push and pop keeps the count
      txSet(3); applyStimulus(1, 0);
      txSet(4); applyStimulus(1, 0);
      txSet(5); net_tx_ready = 1'b1; applyStimulus(1, 0);
      checkOutput("tx_count_pushpop", tx_count, 2);
      applyStimulus(0, 0);
      applyStimulus(0, 0);
      net_tx_ready = 1'b0;
      checkOutput("tx_count_zero", tx_count, 0);

      // Overflow: fill, drop, clear, drop under a concurrent pop, clear-vs-set priority
      for (int i = 0; i < DEPTH; i++) begin
         txSet(100 + i);
         applyStimulus(1, 0);
      end
      checkOutput("tx_full", core_full, 1);
      checkOutput("tx_count_full", tx_count, 64);
      checkOutput("ovf_not_yet", err_overflow, 0);
      txSet(200); applyStimulus(0, 0);
      checkOutput("ovf_set", err_overflow, 1);
      checkOutput("tx_count_drop", tx_count, 64);
      err_clear = 1'b1; applyStimulus(0, 0);
      checkOutput("ovf_cleared", err_overflow, 0);
      txSet(201); net_tx_ready = 1'b1; applyStimulus(0, 0);
      net_tx_ready = 1'b0;
      checkOutput("ovf_with_pop", err_overflow, 1);
      checkOutput("tx_count_pop_drop", tx_count, 63);
      txSet(202); applyStimulus(1, 0);
      checkOutput("ovf_sticky", err_overflow, 1);
      txSet(203); err_clear = 1'b1; applyStimulus(0, 0);
      checkOutput("ovf_set_wins", err_overflow, 1);
      err_clear = 1'b1; applyStimulus(0, 0);
      checkOutput("ovf_cleared2", err_overflow, 0);
      net_tx_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++)
         applyStimulus(0, 0);
      net_tx_ready = 1'b0;
      checkOutput("tx_count_drained", tx_count, 0);

      // Underflow on empty RX
      core_read_en = 1'b1; applyStimulus(0, 0);
      checkOutput("udf_count", rx_count, 0);
      checkOutput("udf_set", err_underflow, 1);
      checkOutput("udf_data", core_read_data, 0);
      checkOutput("udf_empty", core_empty, 1);
      err_clear = 1'b1; applyStimulus(0, 0);
      checkOutput("udf_cleared", err_underflow, 0);

      // RX threshold
      thresh_level = 7'd4;
      for (int i = 0; i < 4; i++) begin
         rxSet(i);
         applyStimulus(0, 1);
         checkOutput("rx_count_fill", rx_count, 7'(i + 1));
         checkOutput("thresh_rise", core_thresh, (i == 3) ? 64'd1 : 64'd0);
      end
      core_read_en = 1'b1; applyStimulus(0, 0);
      checkOutput("thresh_fall", core_thresh, 0);
      checkOutput("rx_count_pop", rx_count, 3);
      thresh_level = 7'd3; #1;
      checkOutput("thresh_eq", core_thresh, 1);
      thresh_level = 7'd0; #1;
      checkOutput("thresh_zero", core_thresh, 0);
      thresh_level = 7'd65; #1;
      checkOutput("thresh_over", core_thresh, 0);
      thresh_level = 7'd4;
      for (int i = 0; i < 3; i++) begin
         core_read_en = 1'b1;
         applyStimulus(0, 0);
      end
      checkOutput("rx_empty", core_empty, 1);

      // RX full, then 200 concurrent cycles across pointer wrap
      for (int i = 0; i < DEPTH; i++) begin
         rxSet(300 + i);
         applyStimulus(0, 1);
      end
      checkOutput("rx_ready_full", net_rx_ready, 0);
      checkOutput("rx_count_full", rx_count, 64);
      rxSet(400); applyStimulus(0, 0);
      checkOutput("rx_count_blocked", rx_count, 64);
      for (int i = 0; i < 4; i++) begin
         core_read_en = 1'b1;
         applyStimulus(0, 0);
      end
      checkOutput("rx_count_60", rx_count, 60);
      for (int i = 0; i < 200; i++) begin
         rxSet(500 + i);
         core_read_en = 1'b1;
         applyStimulus(0, 1);
      end
      checkOutput("rx_count_wrap", rx_count, 60);
      for (int i = 0; i < 60; i++) begin
         core_read_en = 1'b1;
         applyStimulus(0, 0);
      end
      checkOutput("rx_count_end", rx_count, 0);

      txSet(600); applyStimulus(1, 0);
      txSet(601); applyStimulus(1, 0);
      net_tx_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         txSet(602 + i);
         applyStimulus(1, 0);
      end
      checkOutput("tx_count_wrap", tx_count, 2);
      applyStimulus(0, 0);
      applyStimulus(0, 0);
      net_tx_ready = 1'b0;
      checkOutput("tx_count_end", tx_count, 0);

      // Asynchronous reset with words queued
      for (int i = 0; i < 10; i++) begin
         txSet(700 + i);
         rxSet(700 + i);
         applyStimulus(1, 1);
      end
      reset = 1'b1;
      #1;
      checkOutput("arst_tx_count", tx_count, 0);
      checkOutput("arst_rx_count", rx_count, 0);
      checkOutput("arst_core_empty", core_empty, 1);
      checkOutput("arst_tx_valid", net_tx_valid, 0);
      checkOutput("arst_rx_ready", net_rx_ready, 0);
      txq.delete();
      rxq.delete();
      applyStimulus(0, 0);
      reset = 1'b0;
      applyStimulus(0, 0);
      checkOutput("post_rst_tx_valid", net_tx_valid, 0);
      checkOutput("post_rst_empty", core_empty, 1);
      txSet(800); applyStimulus(1, 0);
      net_tx_ready = 1'b1; applyStimulus(0, 0);
      net_tx_ready = 1'b0;

      checkOutput("txq_drained", 64'(txq.size()), 0);
      checkOutput("rxq_drained", 64'(rxq.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
